// File: rtl/vx_dot8_commit_buffer_pkg.sv
// vx_dot8_commit_buffer_pkg: shared DOT8 beat geometry and tag field layout
package vx_dot8_commit_buffer_pkg;
  localparam int NUM_THREADS = 8;
  localparam int DOT8_LANES = 4;
  function automatic int beats_for(input int threads, input int lanes);
    return (threads + lanes - 1) / lanes;
  endfunction
  localparam int DOT8_MAX_BEATS = beats_for(NUM_THREADS, DOT8_LANES);
  typedef struct packed {
    logic [11:0] uuid;
    logic [1:0]  wid;
    logic [7:0]  tmask;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wb;
    logic [3:0]  pid;
  } dot8_tag_t;
  localparam int DOT8_TAG_WIDTH = $bits(dot8_tag_t);
endpackage

// File: rtl/vx_dot8_commit_buffer_pkt_fifo.sv
// vx_dot8_pkt_fifo: register-array circular buffer of packet beats with occupancy count
module vx_dot8_pkt_fifo
  import vx_dot8_commit_buffer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;
  // power-of-2 depth lets the pointers wrap on their own
  always_ff @(posedge clk)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/vx_dot8_commit_buffer.sv
// vx_dot8_commit_buffer: store-and-forward DOT8 result buffer releasing only complete packets
module vx_dot8_commit_buffer
  import vx_dot8_commit_buffer_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int XLEN = 32,
  parameter int TAG_WIDTH = DOT8_TAG_WIDTH,
  parameter int MAX_BEATS = DOT8_MAX_BEATS,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [NUM_LANES*XLEN-1:0] data_in,
  input  logic [TAG_WIDTH-1:0]      tag_in,
  input  logic                      sop_in,
  input  logic                      eop_in,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [NUM_LANES*XLEN-1:0] data_out,
  output logic [TAG_WIDTH-1:0]      tag_out,
  output logic                      sop_out,
  output logic                      eop_out,
  output logic [CW-1:0]             occupancy,
  output logic [CW-1:0]             full_pkts
);
  localparam int EW = NUM_LANES * XLEN + TAG_WIDTH + 2;
  localparam int BW = $clog2(MAX_BEATS + 2);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  if (DEPTH < MAX_BEATS || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("DEPTH must be a power of 2 and at least MAX_BEATS");
  end
  logic push, pop, pkt_open;
  logic [BW-1:0] beat_cnt, beat_idx;
  logic [EW-1:0] head;
  assign ready_in = reset && (occupancy != FULL);
  // the FIFO head always belongs to the oldest packet, so any complete packet means the head is releasable
  assign valid_out = (occupancy != '0) && (full_pkts != '0);
  assign push = valid_in && ready_in;
  assign pop = valid_out && ready_out;
  assign beat_idx = sop_in ? BW'(1) : beat_cnt + BW'(1);
  assign {data_out, tag_out, sop_out, eop_out} = head;
  vx_dot8_pkt_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({data_in, tag_in, sop_in, eop_in}),
    .rdata (head),
    .count (occupancy)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      full_pkts <= '0;
      pkt_open  <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      full_pkts <= full_pkts + CW'(push && eop_in) - CW'(pop && eop_out);
      if (push) begin
        pkt_open <= !eop_in;
        beat_cnt <= eop_in ? '0 : beat_idx;
      end
    end
  a_sop_while_open: assert property (@(posedge clk) disable iff (!reset) push && pkt_open |-> !sop_in);
  a_beat_without_sop: assert property (@(posedge clk) disable iff (!reset) push && !pkt_open |-> sop_in);
  a_too_many_beats: assert property (@(posedge clk) disable iff (!reset) push |-> beat_idx <= BW'(MAX_BEATS));
  // a full buffer with no complete packet can never drain
  a_deadlock: assert property (@(posedge clk) disable iff (!reset) occupancy == FULL |-> full_pkts != '0);
endmodule

// File: tb/tb_vx_dot8_commit_buffer.sv
// tb_vx_dot8_commit_buffer: directed table vectors plus fill, reset and wrap-around sequences
module tb_vx_dot8_commit_buffer;
  localparam int DW = 128;
  localparam int TW = 64;
  localparam int CHK_W = DW + TW + 2;
  localparam int NV = 19;
  typedef logic [CHK_W-1:0] beat_t;
  typedef struct {
    logic v, s, e;
    logic [31:0] d;
    logic r;
    logic x_rdy, x_vld;
    logic [2:0] x_occ, x_pkts;
    logic x_sop, x_eop;
    logic [31:0] x_d;
  } vec_t;
  logic clk = 1'b0, reset = 1'b0, valid_in = 1'b0, ready_out = 1'b0, sop_in = 1'b0, eop_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [TW-1:0] tag_in = '0;
  logic ready_in, valid_out, sop_out, eop_out;
  logic [DW-1:0] data_out;
  logic [TW-1:0] tag_out;
  logic [2:0] occupancy, full_pkts;
  logic mon_en = 1'b0, done = 1'b0;
  int checks = 0, passed = 0;
  beat_t out_q[$], exp_q[$];
  vec_t vecs[NV];
  always #5 clk = ~clk;
  vx_dot8_commit_buffer dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .data_in(data_in), .tag_in(tag_in), .sop_in(sop_in), .eop_in(eop_in),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
    .tag_out(tag_out), .sop_out(sop_out), .eop_out(eop_out),
    .occupancy(occupancy), .full_pkts(full_pkts)
  );
  always @(negedge clk)
    if (mon_en && valid_out && ready_out) out_q.push_back({data_out, tag_out, sop_out, eop_out});
  function automatic logic [DW-1:0] mk_data(input logic [31:0] d);
    return {d + 32'd3, d + 32'd2, d + 32'd1, d};
  endfunction
  function automatic logic [TW-1:0] mk_tag(input logic [31:0] d);
    return {~d, d ^ 32'h5A5A_0000};
  endfunction
  function automatic beat_t mk_beat(input logic [31:0] d, input logic s, input logic e);
    return {mk_data(d), mk_tag(d), s, e};
  endfunction
  function automatic vec_t mkv(input logic v, s, e, input logic [31:0] d, input logic r,
                               input logic x_rdy, x_vld, input logic [2:0] x_occ, x_pkts,
                               input logic x_sop, x_eop, input logic [31:0] x_d);
    return '{v, s, e, d, r, x_rdy, x_vld, x_occ, x_pkts, x_sop, x_eop, x_d};
  endfunction
  task automatic chk(input string name, input beat_t act, input beat_t exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic drive_in(input logic v, input logic s, input logic e, input logic [31:0] d);
    valid_in = v; sop_in = s; eop_in = e; data_in = mk_data(d); tag_in = mk_tag(d);
  endtask
  task automatic drive(input logic v, input logic s, input logic e, input logic [31:0] d, input logic r);
    drive_in(v, s, e, d);
    ready_out = r;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_state(input string name, input logic rdy, input logic vld, input logic [2:0] occ, input logic [2:0] pk);
    chk({name, " ready_in"}, CHK_W'(ready_in), CHK_W'(rdy));
    chk({name, " valid_out"}, CHK_W'(valid_out), CHK_W'(vld));
    chk({name, " occupancy"}, CHK_W'(occupancy), CHK_W'(occ));
    chk({name, " full_pkts"}, CHK_W'(full_pkts), CHK_W'(pk));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    // each row: expected state at the start of the cycle, then the inputs applied in that cycle
    vecs[0]  = mkv(1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 32'h00);
    vecs[1]  = mkv(1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 32'h00);
    vecs[2]  = mkv(1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 32'h10);
    vecs[3]  = mkv(1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 32'h00);
    vecs[4]  = mkv(1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 32'h00);
    vecs[5]  = mkv(1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 32'h00);
    vecs[6]  = mkv(1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 32'h00);
    vecs[7]  = mkv(1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 32'h00);
    vecs[8]  = mkv(1'b1, 1'b0, 1'b1, 32'h21, 1'b1, 1'b1, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 32'h00);
    vecs[9]  = mkv(1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 3'd2, 3'd1, 1'b1, 1'b0, 32'h20);
    vecs[10] = mkv(1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 3'd1, 3'd1, 1'b0, 1'b1, 32'h21);
    vecs[11] = mkv(1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 32'h00);
    vecs[12] = mkv(1'b1, 1'b1, 1'b1, 32'h30, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 32'h00);
    vecs[13] = mkv(1'b1, 1'b1, 1'b1, 32'h31, 1'b0, 1'b1, 1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 32'h30);
    vecs[14] = mkv(1'b1, 1'b1, 1'b1, 32'h32, 1'b1, 1'b1, 1'b1, 3'd2, 3'd2, 1'b1, 1'b1, 32'h30);
    vecs[15] = mkv(1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 3'd2, 3'd2, 1'b1, 1'b1, 32'h31);
    vecs[16] = mkv(1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 3'd2, 3'd2, 1'b1, 1'b1, 32'h31);
    vecs[17] = mkv(1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 32'h32);
    vecs[18] = mkv(1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 32'h00);
    tick();
    tick();
    chk_state("reset", 1'b0, 1'b0, 3'd0, 3'd0);
    reset = 1'b1;
    tick();
    for (int i = 0; i < NV; i++) begin
      chk_state($sformatf("vec%0d", i), vecs[i].x_rdy, vecs[i].x_vld, vecs[i].x_occ, vecs[i].x_pkts);
      if (vecs[i].x_vld)
        chk($sformatf("vec%0d head", i), {data_out, tag_out, sop_out, eop_out},
            mk_beat(vecs[i].x_d, vecs[i].x_sop, vecs[i].x_eop));
      drive(vecs[i].v, vecs[i].s, vecs[i].e, vecs[i].d, vecs[i].r);
      tick();
    end
    // fill to capacity with the arbiter stalled, then try one beat too many
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h40 + 32'(i), 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 32'h4F, 1'b0);
    chk_state("full", 1'b0, 1'b1, 3'd4, 3'd4);
    tick();
    chk_state("full hold", 1'b0, 1'b1, 3'd4, 3'd4);
    out_q.delete();
    mon_en = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    n = 0;
    while (out_q.size() < 4 && n < 20) begin
      tick();
      n++;
    end
    mon_en = 1'b0;
    chk("drain count", CHK_W'(out_q.size()), CHK_W'(4));
    for (int i = 0; i < out_q.size() && i < 4; i++)
      chk($sformatf("drain beat%0d", i), out_q[i], mk_beat(32'h40 + 32'(i), 1'b1, 1'b1));
    chk_state("drained", 1'b1, 1'b0, 3'd0, 3'd0);
    // reset with two complete packets and one open packet held
    drive(1'b1, 1'b1, 1'b1, 32'h50, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'h51, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h52, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_state("pre-reset", 1'b1, 1'b1, 3'd3, 3'd2);
    reset = 1'b0;
    tick();
    chk_state("mid-reset", 1'b0, 1'b0, 3'd0, 3'd0);
    reset = 1'b1;
    tick();
    chk_state("post-reset", 1'b1, 1'b0, 3'd0, 3'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h55, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_state("post-reset push", 1'b1, 1'b1, 3'd1, 3'd1);
    chk("post-reset head", {data_out, tag_out, sop_out, eop_out}, mk_beat(32'h55, 1'b1, 1'b1));
    tick();
    chk_state("post-reset pop", 1'b1, 1'b0, 3'd0, 3'd0);
    // wrap-around: ten two-beat packets against a randomly stalling arbiter
    out_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
    fork
      begin
        for (int p = 0; p < 10; p++)
          for (int b = 0; b < 2; b++) begin
            logic [31:0] d;
            int w;
            d = 32'h100 + 32'(p * 16 + b);
            drive_in(1'b1, b == 0, b == 1, d);
            exp_q.push_back(mk_beat(d, b == 0, b == 1));
            w = 0;
            while (!ready_in && w < 50) begin
              tick();
              w++;
            end
            chk($sformatf("wrap accept p%0d b%0d", p, b), CHK_W'(ready_in), CHK_W'(1'b1));
            tick();
          end
        drive_in(1'b0, 1'b0, 1'b0, 32'h0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          ready_out = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    ready_out = 1'b1;
    n = 0;
    while (out_q.size() < 20 && n < 60) begin
      tick();
      n++;
    end
    mon_en = 1'b0;
    chk("wrap count", CHK_W'(out_q.size()), CHK_W'(20));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      chk($sformatf("wrap beat%0d", i), out_q[i], exp_q[i]);
    chk_state("wrap end", 1'b1, 1'b0, 3'd0, 3'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
